msrv32_pipe_reg_stage: RTL

MSRV32_PIPE_REG_STAGE -- requirements
Module: msrv32_pipe_reg_stage

---
 rtl/msrv32_pipe_pkg.sv | 14 +
 rtl/msrv32_skid_slice.sv | 81 ++++++++
 rtl/msrv32_pipe_reg_stage.sv | 91 +++++++++
 3 files changed

// File: rtl/msrv32_pipe_pkg.sv
// Shared constants for the msrv32 pipeline register stage.
//   DEF_WIDTH  : default payload width in bits
//   DEF_DEPTH  : default number of cascaded skid slices
//   cnt_width(): width needed to hold an occupancy of 0 .. 2*depth
package msrv32_pipe_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_DEPTH = 2;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/msrv32_skid_slice.sv
// One pipeline slice: a main register feeding the output plus a skid
// register that absorbs one word when the output is stalled.
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   flush_i         : synchronous clear of both valid bits (payload kept)
//   in_valid_i/in_data_i/in_ready_o    : upstream handshake
//   out_valid_o/out_data_o/out_ready_i : downstream handshake
// in_ready_o depends only on the skid valid flop, so no combinational
// path exists from out_ready_i back to in_ready_o.
module msrv32_skid_slice
  import msrv32_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             out_ready_i
);

  logic             main_v_q, main_v_d;
  logic             skid_v_q, skid_v_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             in_fire;
  logic             main_free;

  assign in_ready_o  = ~skid_v_q;
  assign out_valid_o = main_v_q;
  assign out_data_o  = main_data_q;

  assign in_fire   = in_valid_i & ~skid_v_q;
  // Main register can take a new word when empty or drained this cycle.
  assign main_free = ~main_v_q | out_ready_i;

  always_comb begin
    main_v_d    = main_v_q;
    skid_v_d    = skid_v_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    if (flush_i) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (main_free) begin
      if (skid_v_q) begin
        // Skid holds the older word; in_fire is 0 here since ready was low.
        main_v_d    = 1'b1;
        main_data_d = skid_data_q;
        skid_v_d    = 1'b0;
      end else begin
        main_v_d = in_fire;
        if (in_fire) begin
          main_data_d = in_data_i;
        end
      end
    end else if (in_fire) begin
      skid_v_d    = 1'b1;
      skid_data_d = in_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_v_q    <= 1'b0;
      skid_v_q    <= 1'b0;
      main_data_q <= '0;
      skid_data_q <= '0;
    end else begin
      main_v_q    <= main_v_d;
      skid_v_q    <= skid_v_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
    end
  end

endmodule

// File: rtl/msrv32_pipe_reg_stage.sv
// Pipeline register stage: DEPTH cascaded skid slices with flush and an
// occupancy counter. Capacity is 2*DEPTH words, strictly FIFO.
// Ports:
//   clk_in, reset_in (async, active-low), flush_in (sync kill)
//   up_valid_in/up_data_in/up_ready_out : upstream handshake
//   dn_valid_out/dn_data_out/dn_ready_in : downstream handshake
//   count_out : number of valid entries held
// flush_in masks both handshakes combinationally so no transfer happens
// in the flush cycle.
module msrv32_pipe_reg_stage
  import msrv32_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             flush_in,
  input  logic             up_valid_in,
  input  logic [WIDTH-1:0] up_data_in,
  output logic             up_ready_out,
  output logic             dn_valid_out,
  output logic [WIDTH-1:0] dn_data_out,
  input  logic             dn_ready_in,
  output logic [CNT_W-1:0] count_out
);

  if (DEPTH < 1) begin : g_bad_depth
    $error("msrv32_pipe_reg_stage: DEPTH must be >= 1");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("msrv32_pipe_reg_stage: WIDTH must be >= 1");
  end

  // Link g connects slice g-1 output to slice g input; link 0 is upstream.
  logic [DEPTH:0]   link_valid;
  logic [DEPTH:0]   link_ready;
  logic [WIDTH-1:0] link_data [DEPTH+1];

  logic             up_fire;
  logic             dn_fire;
  logic [CNT_W-1:0] count_q, count_d;

  assign link_valid[0]     = up_valid_in;
  assign link_data[0]      = up_data_in;
  assign link_ready[DEPTH] = dn_ready_in;

  for (genvar g = 0; g < DEPTH; g++) begin : g_slice
    msrv32_skid_slice #(
      .WIDTH(WIDTH)
    ) u_slice (
      .clk_i      (clk_in),
      .rst_ni     (reset_in),
      .flush_i    (flush_in),
      .in_valid_i (link_valid[g]),
      .in_data_i  (link_data[g]),
      .in_ready_o (link_ready[g]),
      .out_valid_o(link_valid[g+1]),
      .out_data_o (link_data[g+1]),
      .out_ready_i(link_ready[g+1])
    );
  end

  assign up_ready_out = link_ready[0] & ~flush_in;
  assign dn_valid_out = link_valid[DEPTH] & ~flush_in;
  assign dn_data_out  = link_data[DEPTH];

  assign up_fire = up_valid_in & up_ready_out;
  assign dn_fire = dn_valid_out & dn_ready_in;

  always_comb begin
    count_d = count_q;
    if (flush_in) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(up_fire) - CNT_W'(dn_fire);
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out = count_q;

endmodule
